// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, one outstanding imem request, prefetch FIFO to IF/ID.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_bubbles saturating counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       bus,
  output logic [31:0]           pc_out,
  output logic [31:0]           instr_out,
  output logic                  valid_out,
  output logic                  flush_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t             state, state_next;
  logic [31:0]        fetch_pc;
  logic [31:0]        discard_addr;
  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [31:0]        fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  // A request held in FETCH never loses its slot: count cannot grow until that request is acked.
  always_comb begin
    state_next     = state;
    bus.imem_req   = 1'b0;
    bus.imem_addr  = fetch_pc;
    push           = 1'b0;
    case (state)
      FETCH: begin
        bus.imem_req = rst && (count < CNT_W'(FIFO_DEPTH));
        push         = bus.imem_req && bus.imem_ack && !redirect_valid;
        if (redirect_valid && bus.imem_req && !bus.imem_ack) state_next = DISCARD;
      end
      DISCARD: begin
        bus.imem_req  = rst;
        bus.imem_addr = discard_addr;
        if (bus.imem_ack) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  assign valid_out = (count != '0);
  assign pop       = valid_out && !stall && !redirect_valid;
  assign flush_out = redirect_valid && rst;
  assign pc_out    = valid_out ? fifo_pc[rd_ptr]    : 32'h0;
  assign instr_out = valid_out ? fifo_instr[rd_ptr] : NOP_INSTR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= RESET_PC;
      discard_addr <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (state == FETCH) discard_addr <= bus.imem_addr;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= bus.imem_addr;
      fifo_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (push && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      if (!valid_out && !stall && perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: variable-latency imem responder, queue-based reference
// model compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_if_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_out, instr_out;
  logic        valid_out, flush_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (imem_bus),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .valid_out      (valid_out),
    .flush_out      (flush_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus knobs and responder state
  logic        stall_v = 1'b0, redir_v = 1'b0;
  logic [31:0] rpc_v = '0;
  int          lat_mode = 0;
  logic        busy = 1'b0, ack_prev = 1'b0;
  int          left = 0;

  // Reference model: FIFO contents as a queue of fetched (pc, word) pairs
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      q[$];
  logic [31:0] m_fpc;
  logic        m_disc;
  logic [31:0] m_daddr;
  int unsigned m_fetched, m_bubbles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc     = RPC;
    m_disc    = 1'b0;
    m_daddr   = '0;
    m_fetched = 0;
    m_bubbles = 0;
    busy      = 1'b0;
    ack_prev  = 1'b0;
    left      = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    stall = 1'b0; redirect_valid = 1'b0;
    imem_bus.imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
    chk("rst_addr",  imem_bus.imem_addr, RPC);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_flush", {31'b0, flush_out}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_bubbles", perf_bubbles, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle: drive, respond, compare DUT against model, advance model
  task automatic cycle();
    logic        ack;
    logic [31:0] rd;
    logic        m_req, m_valid, acc;
    logic [31:0] m_addr, m_pc, m_instr;
    @(posedge clk); #1;
    stall          = stall_v;
    redirect_valid = redir_v;
    redirect_pc    = rpc_v;
    if (ack_prev || !imem_bus.imem_req) busy = 1'b0;
    if (imem_bus.imem_req && !busy) begin
      busy = 1'b1;
      left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end else if (busy && left > 0) begin
      left--;
    end
    ack      = busy && (left == 0);
    ack_prev = ack;
    rd       = $urandom;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rd;
    #2;
    m_req   = m_disc || (q.size() < DEPTH);
    m_addr  = m_disc ? m_daddr : m_fpc;
    m_valid = (q.size() != 0);
    m_pc    = m_valid ? q[0].pc : 32'h0;
    m_instr = m_valid ? q[0].instr : NOP;
    chk("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem_bus.imem_addr, m_addr);
    chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    chk("pc_out",    pc_out, m_pc);
    chk("instr_out", instr_out, m_instr);
    chk("flush_out", {31'b0, flush_out}, {31'b0, redir_v});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_bubbles", perf_bubbles, m_bubbles);
    if (!m_valid && !stall_v) m_bubbles++;
`endif
    acc = m_req && ack;
    if (redir_v) begin
      q.delete();
      if (m_disc) begin
        if (acc) m_disc = 1'b0;
      end else if (m_req && !ack) begin
        m_disc  = 1'b1;
        m_daddr = m_fpc;
      end
      m_fpc = rpc_v & ~32'h3;
    end else if (m_disc) begin
      if (acc) m_disc = 1'b0;
    end else begin
      if (m_valid && !stall_v) void'(q.pop_front());
      if (acc) begin
        q.push_back('{pc: m_fpc, instr: rd});
        m_fpc = m_fpc + 32'd4;
        m_fetched++;
      end
    end
  endtask

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    model_reset();

    // Zero-wait streaming, then stall until full and drain
    lat_mode = 0; stall_v = 1'b0; redir_v = 1'b0;
    do_reset();
    cycle(); chk("t1_addr0", imem_bus.imem_addr, 32'h0); chk("t1_valid0", {31'b0, valid_out}, 32'h0);
    chk("t1_nop", instr_out, 32'h0000_0013);
    cycle(); chk("t1_addr1", imem_bus.imem_addr, 32'h4); chk("t1_pc1", pc_out, 32'h0);
    chk("t1_valid1", {31'b0, valid_out}, 32'h1);
    cycle(); chk("t1_addr2", imem_bus.imem_addr, 32'h8); chk("t1_pc2", pc_out, 32'h4);
    stall_v = 1'b1;
    repeat (5) cycle();
    chk("t2_full_req", {31'b0, imem_bus.imem_req}, 32'h0); chk("t2_head", pc_out, 32'h8);
    stall_v = 1'b0;
    cycle(); cycle();
    chk("t2_pc", pc_out, 32'hC); chk("t2_addr", imem_bus.imem_addr, 32'h10);

    // Delayed ack, then redirect while a request is outstanding
    lat_mode = 3;
    do_reset();
    repeat (3) cycle();
    chk("t3_addr_held", imem_bus.imem_addr, 32'h0); chk("t3_empty", {31'b0, valid_out}, 32'h0);
    chk("t3_nop", instr_out, 32'h0000_0013);
    cycle(); cycle();
    chk("t3_pc", pc_out, 32'h0);
    redir_v = 1'b1; rpc_v = 32'h200;
    cycle(); chk("t4_flush", {31'b0, flush_out}, 32'h1);
    redir_v = 1'b0;
    cycle(); chk("t4_empty", {31'b0, valid_out}, 32'h0); chk("t4_old_addr", imem_bus.imem_addr, 32'h4);
    cycle(); cycle(); chk("t4_new_addr", imem_bus.imem_addr, 32'h200);
    repeat (4) cycle(); chk("t4_pc", pc_out, 32'h200);

    // Redirect coinciding with stall and ack, misaligned target
    lat_mode = 0; stall_v = 1'b1;
    do_reset();
    cycle();
    redir_v = 1'b1; rpc_v = 32'h303;
    cycle(); chk("t5_flush", {31'b0, flush_out}, 32'h1);
    redir_v = 1'b0;
    cycle(); chk("t5_empty", {31'b0, valid_out}, 32'h0); chk("t5_addr", imem_bus.imem_addr, 32'h300);
    cycle(); chk("t5_pc", pc_out, 32'h300);
    stall_v = 1'b0;

    // Reset while a request is outstanding
    lat_mode = 3;
    do_reset();
    cycle(); cycle();
    do_reset();
    cycle(); chk("t6_addr", imem_bus.imem_addr, RPC); chk("t6_req", {31'b0, imem_bus.imem_req}, 32'h1);

    // Random traffic
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      stall_v = ($urandom_range(0, 9) < 3);
      redir_v = ($urandom_range(0, 11) == 0);
      rpc_v   = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle();
    end
    redir_v = 1'b0;
    stall_v = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues one request at a time to instruction memory over a req/ack handshake with variable latency. Returned words are buffered in a small prefetch FIFO that presents {pc, instr} to IF/ID. The block honours stall from the hazard unit and PC redirects from EX branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 2, prefetch entries; power of two, legal range 2..8
NOP_INSTR, 32'h0000_0013, instruction driven when the FIFO is empty (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-low reset
stall  in  1  IF/ID hold; head entry is not consumed this cycle
redirect_valid  in  1  branch/jump taken; single-cycle pulse
redirect_pc  in  32  target PC, valid with redirect_valid
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; word aligned
imem_ack  in  1  response valid; allowed in the same cycle as imem_req (zero wait)
imem_rdata  in  32  instruction word, valid with imem_ack
pc_out  out  32  head PC to IF/ID; 0 when empty
instr_out  out  32  head instruction; NOP_INSTR when empty
valid_out  out  1  FIFO non-empty
flush_out  out  1  combinational copy of redirect_valid; drives the IF/ID flush

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC; FIFO empty; state=FETCH; no request outstanding. Outputs: imem_req=0, imem_addr=RESET_PC, valid_out=0, pc_out=0, instr_out=NOP_INSTR, flush_out=0.
- States: FETCH, DISCARD.
- FETCH: imem_req=1 whenever count + outstanding < FIFO_DEPTH. Then imem_addr=fetch_pc. Once asserted, req and addr stay stable until ack.
- On ack in FETCH without a redirect: push {imem_addr, imem_rdata} and set fetch_pc += 4, wrapping modulo 2^32.
- Latency: a zero-wait ack at edge N makes the entry visible on valid_out at cycle N+1.
- Pop: head is consumed when valid_out=1, stall=0 and redirect_valid=0. Push and pop in the same cycle are allowed at any occupancy, including full.
- Full: no new request is issued. An outstanding request is always guaranteed a slot.
- Redirect, with priority over stall and push:
  - FIFO is cleared and fetch_pc=redirect_pc.
  - If a request is outstanding and imem_ack=0 that cycle, go to DISCARD.
  - If imem_ack=1 in the redirect cycle, drop the data and stay in FETCH.
- DISCARD:
  - Keep imem_req=1 with the old address until ack. Drop the returned data, do not push, then return to FETCH.
  - The new fetch is issued in the cycle after the discard ack.
  - A further redirect while in DISCARD only updates fetch_pc.
- redirect_pc[1:0]≠0: the low bits are forced to 0.
- Reset mid-request: all state is cleared. Any ack that arrives after reset deasserts with no request outstanding is ignored.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0].
  - perf_fetched increments on each push.
  - perf_bubbles increments each cycle with valid_out=0, stall=0 and rst=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and counters do not exist.

Test Plan:
1. Reset, then zero-wait ack, stall=0 → addrs 0x0,0x4,0x8… on consecutive cycles; valid_out=1 from the 2nd cycle; pc_out tracks addr one cycle later.
2. stall=1 held for 5 cycles, zero-wait memory → FIFO fills with 2 entries, imem_req=0; head pc=0x0 stays stable. After stall=0, entries pop in order and fetching resumes at 0x8.
3. Request to 0x10 with ack delayed 3 cycles → imem_addr=0x10 held stable; valid_out=0 and instr_out=0x00000013 while empty; perf_bubbles counts those cycles (macro on).
4. Redirect to 0x200 while 0x10 is outstanding (ack 2 cycles later) → flush_out=1 for one cycle; FIFO empty; 0x10 data dropped; next imem_addr=0x200; pc_out=0x200 after its ack.
5. redirect_valid=1 with stall=1 and imem_ack=1 in the same cycle → data dropped, FIFO cleared, no DISCARD entry; next request goes to redirect_pc.
6. rst pulsed low during an outstanding request → outputs return to reset values immediately; fetching restarts at RESET_PC.
